// File: rtl/led_sequencer.sv
// ============================================================================
// led_sequencer
//
// Owns the two green board LEDs and plays timed blink patterns on them. A
// requester hands over a pattern mode and a step count through a valid/ready
// handshake. The block splits the clock into steps of DIV cycles, shows one
// pattern value per step, and pulses `done` when a finite run has finished.
// A run with count 0 goes on until a new command replaces it. A finite run
// cannot be interrupted by a new command.
//
// Parameters
//   DIV        clock cycles per pattern step (must be >= 1)
//
// Ports
//   CLOCK_50   in   1  board clock; all state changes on its rising edge
//   RESET_N    in   1  synchronous active-low reset
//   cmd_valid  in   1  a command is present on cmd_mode/cmd_count
//   cmd_mode   in   2  00 OFF, 01 BLINK, 10 ALT, 11 COUNT
//   cmd_count  in   8  number of steps to run, 0 = run until pre-empted
//   cmd_ready  out  1  a command is accepted this cycle if cmd_valid is high
//   LEDG       out  2  registered LED drive
//   busy       out  1  registered, high while a run is in progress
//   done       out  1  one-cycle pulse after a finite run completes
// ============================================================================
module led_sequencer #(
    parameter int DIV = 25_000_000
) (
    input  logic       CLOCK_50,
    input  logic       RESET_N,
    input  logic       cmd_valid,
    input  logic [1:0] cmd_mode,
    input  logic [7:0] cmd_count,
    output logic       cmd_ready,
    output logic [1:0] LEDG,
    output logic       busy,
    output logic       done
);

    // The prescaler needs at least one bit, even when DIV is 1.
    localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(DIV - 1);

    localparam logic [1:0] MODE_OFF   = 2'b00;
    localparam logic [1:0] MODE_BLINK = 2'b01;
    localparam logic [1:0] MODE_ALT   = 2'b10;
    localparam logic [1:0] MODE_COUNT = 2'b11;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    state_e          state_q,     state_d;
    logic [1:0]      mode_q,      mode_d;
    logic [1:0]      step_q,      step_d;
    logic [7:0]      remaining_q, remaining_d;
    logic [PW-1:0]   presc_q,     presc_d;
    logic            infinite_q,  infinite_d;
    logic [1:0]      ledg_q,      ledg_d;
    logic            busy_q,      busy_d;
    logic            done_q,      done_d;

    logic            accept;

    // LED value shown for a given mode during a given step.
    function automatic logic [1:0] pattern(input logic [1:0] mode,
                                           input logic [1:0] step);
        logic [1:0] value;
        value = 2'b00;
        case (mode)
            MODE_OFF:   value = 2'b00;
            MODE_BLINK: value = step[0] ? 2'b00 : 2'b11;
            MODE_ALT:   value = step[0] ? 2'b10 : 2'b01;
            MODE_COUNT: value = step;
            default:    value = 2'b00;
        endcase
        return value;
    endfunction

    // State register. Reset also drops any command presented during reset,
    // and because done_q is cleared here an interrupted run never reports done.
    always_ff @(posedge CLOCK_50) begin
        if (!RESET_N) begin
            state_q     <= ST_IDLE;
            mode_q      <= MODE_OFF;
            step_q      <= 2'd0;
            remaining_q <= 8'd0;
            presc_q     <= '0;
            infinite_q  <= 1'b0;
            ledg_q      <= 2'b00;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            mode_q      <= mode_d;
            step_q      <= step_d;
            remaining_q <= remaining_d;
            presc_q     <= presc_d;
            infinite_q  <= infinite_d;
            ledg_q      <= ledg_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    // Next-state logic. An accepted command always wins, so a command that
    // arrives during an infinite run restarts step and prescaler from zero.
    // A finite run ends on the prescaler wrap of its last step.
    always_comb begin
        state_d     = state_q;
        mode_d      = mode_q;
        step_d      = step_q;
        remaining_d = remaining_q;
        presc_d     = presc_q;
        infinite_d  = infinite_q;
        ledg_d      = ledg_q;
        done_d      = 1'b0;

        accept = cmd_valid && cmd_ready;

        if (accept) begin
            state_d     = ST_RUN;
            mode_d      = cmd_mode;
            step_d      = 2'd0;
            presc_d     = '0;
            remaining_d = cmd_count;
            infinite_d  = (cmd_count == 8'd0);
            ledg_d      = pattern(cmd_mode, 2'd0);
        end else if (state_q == ST_RUN) begin
            if (presc_q != PRESC_LAST) begin
                presc_d = presc_q + PW'(1);
            end else if (!infinite_q && remaining_q == 8'd1) begin
                state_d     = ST_IDLE;
                presc_d     = '0;
                step_d      = 2'd0;
                remaining_d = 8'd0;
                ledg_d      = 2'b00;
                done_d      = 1'b1;
            end else begin
                presc_d = '0;
                step_d  = step_q + 2'd1;
                if (!infinite_q) begin
                    remaining_d = remaining_q - 8'd1;
                end
                ledg_d  = pattern(mode_q, step_q + 2'd1);
            end
        end else begin
            ledg_d = 2'b00;
        end

        busy_d = (state_d == ST_RUN);
    end

    // Outputs. Only an idle block or an infinite run will take a command.
    always_comb begin
        cmd_ready = RESET_N && ((state_q == ST_IDLE) ||
                                (state_q == ST_RUN && infinite_q));
        LEDG      = ledg_q;
        busy      = busy_q;
        done      = done_q;
    end

endmodule

// File: tb/tb_led_sequencer.sv
// ============================================================================
// tb_led_sequencer
//
// Directed bench for led_sequencer. One instance runs with DIV=4 for the
// handshake, pattern, pre-emption and reset scenarios; a second instance runs
// with DIV=1 to cover single-cycle steps. Inputs change and outputs are
// sampled 1 ns after each rising clock edge.
// ============================================================================
module tb_led_sequencer;

    logic       clk;
    logic       reset_n;

    logic       cmd_valid;
    logic [1:0] cmd_mode;
    logic [7:0] cmd_count;
    logic       cmd_ready;
    logic [1:0] ledg;
    logic       busy;
    logic       done;

    logic       d1_valid;
    logic [1:0] d1_mode;
    logic [7:0] d1_count;
    logic       d1_ready;
    logic [1:0] d1_ledg;
    logic       d1_busy;
    logic       d1_done;

    int checkCount = 0;
    int passCount  = 0;

    localparam logic [1:0] OFF   = 2'b00;
    localparam logic [1:0] BLINK = 2'b01;
    localparam logic [1:0] ALT   = 2'b10;
    localparam logic [1:0] COUNT = 2'b11;

    led_sequencer #(.DIV(4)) dut (
        .CLOCK_50  (clk),
        .RESET_N   (reset_n),
        .cmd_valid (cmd_valid),
        .cmd_mode  (cmd_mode),
        .cmd_count (cmd_count),
        .cmd_ready (cmd_ready),
        .LEDG      (ledg),
        .busy      (busy),
        .done      (done)
    );

    led_sequencer #(.DIV(1)) dut_div1 (
        .CLOCK_50  (clk),
        .RESET_N   (reset_n),
        .cmd_valid (d1_valid),
        .cmd_mode  (d1_mode),
        .cmd_count (d1_count),
        .cmd_ready (d1_ready),
        .LEDG      (d1_ledg),
        .busy      (d1_busy),
        .done      (d1_done)
    );

    // 50 MHz clock.
    initial clk = 1'b0;
    always #10 clk = ~clk;

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive the command inputs of the DIV=4 instance.
    task automatic applyStimulus(input logic valid, input logic [1:0] mode,
                                 input logic [7:0] count);
        cmd_valid = valid;
        cmd_mode  = mode;
        cmd_count = count;
    endtask

    // Count one comparison and report it if it does not match.
    task automatic checkOutput(input string tag, input logic [7:0] observed,
                               input logic [7:0] expected);
        checkCount++;
        if (observed !== expected) begin
            $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)",
                     tag, observed, expected, $time);
        end else begin
            passCount++;
        end
    endtask

    // Safety net so the run always ends.
    initial begin
        #2_000_000;
        $display("[TB] FAIL timeout: simulation did not finish");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        logic [1:0] expLed;

        reset_n  = 1'b0;
        d1_valid = 1'b0;
        d1_mode  = OFF;
        d1_count = 8'd0;
        applyStimulus(1'b1, BLINK, 8'd3);

        // ---------------- reset with a command present ----------------
        $display("[TB] reset with cmd_valid held");
        for (int i = 0; i < 3; i++) begin
            tick();
            checkOutput("rst_ledg",  8'(ledg),      8'h0);
            checkOutput("rst_busy",  8'(busy),      8'h0);
            checkOutput("rst_done",  8'(done),      8'h0);
            checkOutput("rst_ready", 8'(cmd_ready), 8'h0);
        end
        applyStimulus(1'b0, OFF, 8'd0);
        reset_n = 1'b1;
        tick();
        checkOutput("post_rst_ready", 8'(cmd_ready), 8'h1);
        checkOutput("post_rst_busy",  8'(busy),      8'h0);
        checkOutput("post_rst_ledg",  8'(ledg),      8'h0);

        // ---------------- BLINK, 3 steps ----------------
        $display("[TB] BLINK count 3");
        applyStimulus(1'b1, BLINK, 8'd3);
        tick();
        applyStimulus(1'b0, OFF, 8'd0);
        for (int k = 0; k < 12; k++) begin
            expLed = ((k / 4) % 2 == 0) ? 2'b11 : 2'b00;
            checkOutput("blink_ledg", 8'(ledg), 8'(expLed));
            checkOutput("blink_busy", 8'(busy), 8'h1);
            checkOutput("blink_done", 8'(done), 8'h0);
            tick();
        end
        checkOutput("blink_end_ledg", 8'(ledg), 8'h0);
        checkOutput("blink_end_done", 8'(done), 8'h1);
        checkOutput("blink_end_busy", 8'(busy), 8'h0);
        tick();
        checkOutput("blink_done_drop", 8'(done), 8'h0);

        // ---------------- ALT infinite, pre-empted by COUNT 2 ----------------
        $display("[TB] ALT infinite then COUNT count 2");
        applyStimulus(1'b1, ALT, 8'd0);
        tick();
        applyStimulus(1'b0, OFF, 8'd0);
        for (int k = 0; k < 16; k++) begin
            expLed = ((k / 4) % 2 == 0) ? 2'b01 : 2'b10;
            checkOutput("alt_ledg",  8'(ledg),      8'(expLed));
            checkOutput("alt_ready", 8'(cmd_ready), 8'h1);
            checkOutput("alt_done",  8'(done),      8'h0);
            tick();
        end
        applyStimulus(1'b1, COUNT, 8'd2);
        tick();
        applyStimulus(1'b0, OFF, 8'd0);
        for (int k = 0; k < 8; k++) begin
            expLed = (k < 4) ? 2'b00 : 2'b01;
            checkOutput("cnt_ledg",  8'(ledg),      8'(expLed));
            checkOutput("cnt_busy",  8'(busy),      8'h1);
            checkOutput("cnt_ready", 8'(cmd_ready), 8'h0);
            checkOutput("cnt_done",  8'(done),      8'h0);
            tick();
        end
        checkOutput("cnt_end_done", 8'(done), 8'h1);
        checkOutput("cnt_end_ledg", 8'(ledg), 8'h0);
        checkOutput("cnt_end_busy", 8'(busy), 8'h0);
        tick();
        checkOutput("cnt_done_drop", 8'(done), 8'h0);

        // ---------------- held command accepted in the done cycle ----------------
        $display("[TB] BLINK count 2 with OFF count 1 held");
        applyStimulus(1'b1, BLINK, 8'd2);
        tick();
        applyStimulus(1'b1, OFF, 8'd1);
        for (int k = 0; k < 8; k++) begin
            expLed = (k < 4) ? 2'b11 : 2'b00;
            checkOutput("hold_ledg",  8'(ledg),      8'(expLed));
            checkOutput("hold_ready", 8'(cmd_ready), 8'h0);
            checkOutput("hold_done",  8'(done),      8'h0);
            tick();
        end
        checkOutput("hold_end_done",  8'(done),      8'h1);
        checkOutput("hold_end_ready", 8'(cmd_ready), 8'h1);
        checkOutput("hold_end_busy",  8'(busy),      8'h0);
        tick();
        applyStimulus(1'b0, OFF, 8'd0);
        for (int k = 0; k < 4; k++) begin
            checkOutput("off_ledg", 8'(ledg), 8'h0);
            checkOutput("off_busy", 8'(busy), 8'h1);
            checkOutput("off_done", 8'(done), 8'h0);
            tick();
        end
        checkOutput("off_end_done", 8'(done), 8'h1);
        checkOutput("off_end_busy", 8'(busy), 8'h0);
        tick();

        // ---------------- reset in the middle of a finite run ----------------
        $display("[TB] BLINK count 5 interrupted by reset");
        applyStimulus(1'b1, BLINK, 8'd5);
        tick();
        applyStimulus(1'b0, OFF, 8'd0);
        for (int k = 0; k < 6; k++) begin
            expLed = ((k / 4) % 2 == 0) ? 2'b11 : 2'b00;
            checkOutput("int_ledg", 8'(ledg), 8'(expLed));
            tick();
            if (k == 4) reset_n = 1'b0;
        end
        checkOutput("int_rst_ledg", 8'(ledg), 8'h0);
        checkOutput("int_rst_busy", 8'(busy), 8'h0);
        checkOutput("int_rst_done", 8'(done), 8'h0);
        reset_n = 1'b1;
        for (int k = 0; k < 20; k++) begin
            tick();
            checkOutput("int_no_done", 8'(done), 8'h0);
        end
        applyStimulus(1'b1, ALT, 8'd1);
        tick();
        applyStimulus(1'b0, OFF, 8'd0);
        for (int k = 0; k < 4; k++) begin
            checkOutput("fresh_ledg", 8'(ledg), 8'h1);
            checkOutput("fresh_busy", 8'(busy), 8'h1);
            tick();
        end
        checkOutput("fresh_end_done", 8'(done), 8'h1);
        checkOutput("fresh_end_ledg", 8'(ledg), 8'h0);

        // ---------------- DIV=1, COUNT 6 ----------------
        $display("[TB] DIV=1 COUNT count 6");
        d1_valid = 1'b1;
        d1_mode  = COUNT;
        d1_count = 8'd6;
        tick();
        d1_valid = 1'b0;
        d1_count = 8'd9;
        for (int k = 0; k < 6; k++) begin
            expLed = 2'(k % 4);
            checkOutput("div1_ledg", 8'(d1_ledg), 8'(expLed));
            checkOutput("div1_busy", 8'(d1_busy), 8'h1);
            checkOutput("div1_done", 8'(d1_done), 8'h0);
            tick();
        end
        checkOutput("div1_end_ledg", 8'(d1_ledg), 8'h0);
        checkOutput("div1_end_done", 8'(d1_done), 8'h1);
        checkOutput("div1_end_busy", 8'(d1_busy), 8'h0);
        tick();
        checkOutput("div1_done_drop", 8'(d1_done), 8'h0);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
